// File: rtl/transpose_out_sink.sv
// Output sink for the transpose buffer: a small credit-managed FIFO plus the
// beat/CHin/CHout counters that mark group and transpose boundaries on the head beat.
`ifndef Log2_Trans_pixel
`define Log2_Trans_pixel 9
`endif
`ifndef base_Tin
`define base_Tin 64
`endif
`ifndef base_log2Tin
`define base_log2Tin 6
`endif
`ifndef Tout
`define Tout 32
`endif
`ifndef log2Tout
`define log2Tout 5
`endif
`ifndef log2_CH
`define log2_CH 8
`endif

module transpose_out_sink #(
    parameter int DATA_W      = 256,
    parameter int CREDIT_INIT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [`Log2_Trans_pixel-1:0] pixel_in,
    input  logic [`Log2_Trans_pixel-1:0] pixel_out,
    input  logic                         in_vld,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_vld,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_rdy,
    output logic                         out_last,
    output logic                         out_done,
    output logic                         credit_vld,
    output logic                         ovf_err
);

    localparam int PIX_W         = `Log2_Trans_pixel;
    localparam int CH_W          = `log2_CH;
    localparam int BASE_LOG2_TIN = `base_log2Tin;
    localparam int LOG2_TOUT     = `log2Tout;
    localparam int TOUT          = `Tout;
    localparam int R_SHIFT       = BASE_LOG2_TIN - LOG2_TOUT;
    localparam int BEAT_W        = BASE_LOG2_TIN + 1;
    localparam int LEN_W         = LOG2_TOUT + 1;
    localparam int PTR_W         = (CREDIT_INIT > 1) ? $clog2(CREDIT_INIT) : 1;
    localparam int CNT_W         = $clog2(CREDIT_INIT + 1);

    // ---------------- FIFO ----------------
    logic [DATA_W-1:0] mem [CREDIT_INIT];
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              credit_vld_reg;
    logic              ovf_err_reg, ovf_err_next;
    logic              full, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CREDIT_INIT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_reg == CNT_W'(CREDIT_INIT));
    assign out_vld  = (count_reg != '0);
    assign pop      = out_vld && out_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the beat.
    assign push     = in_vld && (!full || pop);
    assign out_data = mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        ovf_err_next = ovf_err_reg;
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        if (in_vld && !push) begin
            ovf_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            credit_vld_reg <= 1'b0;
            ovf_err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            credit_vld_reg <= pop;
            ovf_err_reg    <= ovf_err_next;
        end
    end

    assign credit_vld = credit_vld_reg;
    assign ovf_err    = ovf_err_reg;

    // ---------------- beat / group counters ----------------
    logic [PIX_W-1:0]  pix_in_m1, pix_out_m1;
    logic [CH_W-1:0]   chin_max, chout_max;
    logic [LEN_W-1:0]  len_last, len;
    logic [BEAT_W-1:0] beat_max;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [CH_W-1:0]   chin_cnt_reg, chin_cnt_next;
    logic [CH_W-1:0]   chout_cnt_reg, chout_cnt_next;
    logic              beat_wrap, chin_wrap, chout_wrap;

    assign pix_in_m1  = pixel_in - PIX_W'(1);
    assign pix_out_m1 = pixel_out - PIX_W'(1);
    assign chout_max  = CH_W'(pix_in_m1 >> LOG2_TOUT);
    assign chin_max   = CH_W'(pix_out_m1 >> BASE_LOG2_TIN);
    // Only the last CHout group may be short; its length is the pixel remainder.
    assign len_last   = LEN_W'(pix_in_m1[LOG2_TOUT-1:0]) + LEN_W'(1);
    assign len        = (chout_cnt_reg == chout_max) ? len_last : LEN_W'(TOUT);
    assign beat_max   = (BEAT_W'(len) << R_SHIFT) - BEAT_W'(1);

    assign beat_wrap  = (beat_cnt_reg == beat_max);
    assign chin_wrap  = (chin_cnt_reg == chin_max);
    assign chout_wrap = (chout_cnt_reg == chout_max);

    assign out_last   = out_vld && beat_wrap;
    assign out_done   = out_last && chin_wrap && chout_wrap;

    always_comb begin
        beat_cnt_next  = beat_cnt_reg;
        chin_cnt_next  = chin_cnt_reg;
        chout_cnt_next = chout_cnt_reg;
        if (pop) begin
            if (!beat_wrap) begin
                beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
            end else begin
                beat_cnt_next = '0;
                if (!chin_wrap) begin
                    chin_cnt_next = chin_cnt_reg + CH_W'(1);
                end else begin
                    chin_cnt_next  = '0;
                    chout_cnt_next = chout_wrap ? '0 : chout_cnt_reg + CH_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_reg  <= '0;
            chin_cnt_reg  <= '0;
            chout_cnt_reg <= '0;
        end else begin
            beat_cnt_reg  <= beat_cnt_next;
            chin_cnt_reg  <= chin_cnt_next;
            chout_cnt_reg <= chout_cnt_next;
        end
    end

endmodule

// File: tb/tb_transpose_out_sink.sv
// Directed bench for transpose_out_sink: single beat, backpressure/overflow,
// full-with-pop, complete 197x192 transpose, reset mid-transpose, credit-honouring reader.
module tb_transpose_out_sink;

    localparam int DATA_W      = 256;
    localparam int CREDIT_INIT = 3;
    localparam int TOTAL_BEATS = 1182;

    logic              clk = 1'b0;
    logic              rst;
    logic [8:0]        pixel_in, pixel_out;
    logic              in_vld;
    logic [DATA_W-1:0] in_data;
    logic              out_vld;
    logic [DATA_W-1:0] out_data;
    logic              out_rdy;
    logic              out_last, out_done, credit_vld, ovf_err;

    int checks = 0;
    int errors = 0;

    transpose_out_sink #(.DATA_W(DATA_W), .CREDIT_INIT(CREDIT_INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pixel_in),
        .pixel_out  (pixel_out),
        .in_vld     (in_vld),
        .in_data    (in_data),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .out_rdy    (out_rdy),
        .out_last   (out_last),
        .out_done   (out_done),
        .credit_vld (credit_vld),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        #1;
        check("rst_vld",    256'(out_vld),    256'(0));
        check("rst_credit", 256'(credit_vld), 256'(0));
        check("rst_ovf",    256'(ovf_err),    256'(0));
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] pat(input int tag, input int i);
        return {DATA_W'(tag) << 200} | DATA_W'(i * 32'h0101_0101 + 7);
    endfunction

    int exp_last [TOTAL_BEATS];
    int exp_done [TOTAL_BEATS];

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed, popped, credits_seen, bad, n_last, n_done, done_idx, k;
        int credits;
        logic [DATA_W-1:0] sb [$];
        logic [DATA_W-1:0] rnd;

        pixel_in  = 9'd197;
        pixel_out = 9'd192;

        // ---- single beat ----
        do_reset();
        in_vld = 1'b1; in_data = pat(1, 0); out_rdy = 1'b1;
        check("t1_vld_pre", 256'(out_vld), 256'(0));
        tick();
        in_vld = 1'b0;
        check("t1_vld",     256'(out_vld),    256'(1));
        check("t1_data",    out_data,         pat(1, 0));
        check("t1_credit0", 256'(credit_vld), 256'(0));
        $display("txn t1 pop data=%0h", out_data[31:0]);
        tick();
        check("t1_credit1", 256'(credit_vld), 256'(1));
        check("t1_empty",   256'(out_vld),    256'(0));
        tick();
        check("t1_credit2", 256'(credit_vld), 256'(0));
        tick();
        check("t1_credit3", 256'(credit_vld), 256'(0));

        // ---- backpressure and overflow ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; in_data = pat(2, i);
            tick();
            check("t2_vld",    256'(out_vld),    256'(1));
            check("t2_head",   out_data,         pat(2, 0));
            check("t2_nocred", 256'(credit_vld), 256'(0));
        end
        in_data = pat(2, 3);
        tick();
        in_vld = 1'b0;
        check("t2_ovf",       256'(ovf_err), 256'(1));
        check("t2_head_ovf",  out_data,      pat(2, 0));
        tick();
        check("t2_ovf_stick", 256'(ovf_err), 256'(1));
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_pop_vld",  256'(out_vld), 256'(1));
            check("t2_pop_data", out_data,      pat(2, i));
            $display("txn t2 pop data=%0h", out_data[31:0]);
            tick();
            check("t2_credit", 256'(credit_vld), 256'(1));
        end
        check("t2_empty", 256'(out_vld), 256'(0));
        tick();
        check("t2_credit_end", 256'(credit_vld), 256'(0));

        // ---- push and pop while full ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; in_data = pat(3, i);
            tick();
        end
        in_data = pat(3, 3); out_rdy = 1'b1;
        tick();
        in_vld = 1'b0; out_rdy = 1'b0;
        check("t3_ovf",    256'(ovf_err),    256'(0));
        check("t3_credit", 256'(credit_vld), 256'(1));
        tick();
        check("t3_credit_once", 256'(credit_vld), 256'(0));
        out_rdy = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check("t3_drain_vld",  256'(out_vld), 256'(1));
            check("t3_drain_data", out_data,      pat(3, i));
            $display("txn t3 pop data=%0h", out_data[31:0]);
            tick();
        end
        check("t3_empty", 256'(out_vld), 256'(0));

        // ---- full transpose 197 x 192 ----
        k = 0;
        for (int co = 0; co < 7; co++) begin
            for (int ci = 0; ci < 3; ci++) begin
                int n;
                n = (co == 6) ? 10 : 64;
                for (int b = 1; b <= n; b++) begin
                    exp_last[k] = (b == n) ? 1 : 0;
                    exp_done[k] = (b == n && co == 6 && ci == 2) ? 1 : 0;
                    k++;
                end
            end
        end
        do_reset();
        pixel_in = 9'd197; pixel_out = 9'd192; out_rdy = 1'b1;
        pushed = 0; popped = 0; credits_seen = 0; bad = 0;
        n_last = 0; n_done = 0; done_idx = -1;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (credit_vld) credits_seen++;
            if (out_vld && out_rdy) begin
                if (out_last !== exp_last[popped][0] || out_done !== exp_done[popped][0]
                    || out_data[31:0] !== 32'(popped))
                    bad++;
                if (out_last) begin
                    n_last++;
                    $display("txn t4 group end beat=%0d done=%0d", popped + 1, out_done);
                end
                if (out_done) begin
                    n_done++;
                    done_idx = popped + 1;
                end
                popped++;
            end
            in_vld  = (pushed < TOTAL_BEATS);
            in_data = DATA_W'(pushed);
            if (in_vld) pushed++;
            tick();
        end
        in_vld = 1'b0;
        check("t4_flag_pattern", 256'(bad),          256'(0));
        check("t4_pops",         256'(popped),       256'(TOTAL_BEATS));
        check("t4_n_last",       256'(n_last),       256'(21));
        check("t4_n_done",       256'(n_done),       256'(1));
        check("t4_done_beat",    256'(done_idx),     256'(1182));
        check("t4_credits",      256'(credits_seen), 256'(TOTAL_BEATS));

        // ---- reset mid-transpose (2-beat transpose: pixel_in=1, pixel_out=1) ----
        do_reset();
        pixel_in = 9'd1; pixel_out = 9'd1; out_rdy = 1'b1;
        in_vld = 1'b1; in_data = pat(5, 0);
        tick();
        check("t5_b1_last", 256'(out_last), 256'(0));
        in_data = pat(5, 1);
        tick();
        check("t5_b2_last", 256'(out_last), 256'(1));
        check("t5_b2_done", 256'(out_done), 256'(1));
        check("t5_b2_data", out_data,       pat(5, 1));
        in_data = pat(5, 2);
        tick();
        check("t5_wrap_last", 256'(out_last), 256'(0));
        in_data = pat(5, 3);
        tick();
        out_rdy = 1'b0; in_data = pat(5, 4);
        tick();
        in_vld = 1'b0;
        check("t5_queued_last", 256'(out_last), 256'(1));
        rst = 1'b1;
        #1;
        check("t5_rst_vld",    256'(out_vld),    256'(0));
        check("t5_rst_last",   256'(out_last),   256'(0));
        check("t5_rst_done",   256'(out_done),   256'(0));
        check("t5_rst_credit", 256'(credit_vld), 256'(0));
        tick();
        check("t5_rst_credit2", 256'(credit_vld), 256'(0));
        rst = 1'b0;
        in_vld = 1'b1; in_data = pat(5, 9); out_rdy = 1'b1;
        tick();
        in_vld = 1'b0;
        check("t5_new_vld",  256'(out_vld),  256'(1));
        check("t5_new_data", out_data,       pat(5, 9));
        check("t5_new_last", 256'(out_last), 256'(0));
        tick();
        check("t5_new_credit", 256'(credit_vld), 256'(1));

        // ---- random out_rdy with a credit-honouring reader ----
        do_reset();
        pixel_in = 9'd197; pixel_out = 9'd192;
        credits = CREDIT_INIT; pushed = 0; popped = 0; bad = 0;
        for (int cyc = 0; cyc < 3000 && !(pushed == 300 && popped == 300); cyc++) begin
            if (credit_vld) credits++;
            out_rdy = 1'($urandom_range(0, 1));
            if (out_vld && out_rdy) begin
                if (sb.size() == 0) begin
                    bad++;
                end else begin
                    if (out_data !== sb[0]) bad++;
                    void'(sb.pop_front());
                end
                popped++;
            end
            in_vld = (pushed < 300) && (credits > 0) && ($urandom_range(0, 3) != 0);
            if (in_vld) begin
                for (int w = 0; w < DATA_W / 32; w++) rnd[w*32 +: 32] = $urandom;
                in_data = rnd;
                sb.push_back(rnd);
                credits--;
                pushed++;
            end
            tick();
        end
        in_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (credit_vld) credits++;
            tick();
        end
        $display("txn t6 pushed=%0d popped=%0d", pushed, popped);
        check("t6_order",   256'(bad),     256'(0));
        check("t6_pops",    256'(popped),  256'(300));
        check("t6_ovf",     256'(ovf_err), 256'(0));
        check("t6_credits", 256'(credits), 256'(CREDIT_INIT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
